// File: rtl/axi_read_slice.sv
// AXI4 read-path register slice.
// Two-entry skid buffers on AR and R, so no valid, ready or payload path
// passes combinationally through the slice. A counter caps the number of
// read bursts that have been accepted but not yet completed.

module axi_read_slice_skid #(
  parameter int Width = 1
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  input  logic             allow_next,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             main_valid_reg, main_valid_next;
  logic             skid_valid_reg, skid_valid_next;
  logic             ready_reg, ready_next;
  logic [Width-1:0] main_data_reg, main_data_next;
  logic [Width-1:0] skid_data_reg, skid_data_next;
  logic             in_fire, out_fire;

  // ready_reg is low whenever the skid holds a beat, so in_fire never
  // coincides with a full skid.
  assign in_fire  = in_valid && ready_reg;
  assign out_fire = main_valid_reg && out_ready;

  // Next-state: refill main from skid, pass input straight to main, or park input in skid
  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (skid_valid_reg) begin
      if (out_fire) begin
        main_valid_next = 1'b1;
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
      end
    end else if (!main_valid_reg || out_fire) begin
      main_valid_next = in_fire;
      if (in_fire) begin
        main_data_next = in_data;
      end
    end else if (in_fire) begin
      skid_valid_next = 1'b1;
      skid_data_next  = in_data;
    end
    ready_next = !skid_valid_next && allow_next;
  end

  // State registers; ready stays low during reset and rises on the first edge after release
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
      main_data_reg  <= '0;
      skid_data_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      ready_reg      <= ready_next;
      main_data_reg  <= main_data_next;
      skid_data_reg  <= skid_data_next;
    end
  end

  assign in_ready  = ready_reg;
  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;

endmodule

module axi_read_slice #(
  parameter int ArPayloadWidth = 41,
  parameter int RPayloadWidth  = 74,
  parameter int MaxOutstanding = 4
) (
  input  logic                                   clk,
  input  logic                                   areset_n,
  input  logic                                   s_ar_valid,
  output logic                                   s_ar_ready,
  input  logic [ArPayloadWidth-1:0]              s_ar_payload,
  output logic                                   m_ar_valid,
  input  logic                                   m_ar_ready,
  output logic [ArPayloadWidth-1:0]              m_ar_payload,
  input  logic                                   m_r_valid,
  output logic                                   m_r_ready,
  input  logic [RPayloadWidth-1:0]               m_r_payload,
  input  logic                                   m_r_last,
  output logic                                   s_r_valid,
  input  logic                                   s_r_ready,
  output logic [RPayloadWidth-1:0]               s_r_payload,
  output logic                                   s_r_last,
  output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  logic [CntW-1:0] count_reg, count_next;
  logic            ar_inc, r_dec;
  logic            ar_allow_next;
  logic [RPayloadWidth:0] r_in_data, r_out_data;

  assign ar_inc = s_ar_valid && s_ar_ready;
  assign r_dec  = s_r_valid && s_r_ready && s_r_last;

  // Outstanding count: simultaneous accept and completion cancel; never drops below zero
  always_comb begin
    count_next = count_reg;
    if (ar_inc && !r_dec) begin
      count_next = count_reg + CntW'(1);
    end else if (r_dec && !ar_inc && count_reg != '0) begin
      count_next = count_reg - CntW'(1);
    end
    ar_allow_next = (count_next < MaxCnt);
  end

  // Outstanding count register
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // A completing last beat with nothing outstanding means a protocol violation upstream
  always @(posedge clk) begin
    if (areset_n) begin
      assert (!(r_dec && !ar_inc && count_reg == '0))
        else $error("axi_read_slice: R last completed with zero outstanding bursts");
    end
  end

  axi_read_slice_skid #(
    .Width (ArPayloadWidth)
  ) u_ar_skid (
    .clk        (clk),
    .areset_n   (areset_n),
    .in_valid   (s_ar_valid),
    .in_ready   (s_ar_ready),
    .in_data    (s_ar_payload),
    .allow_next (ar_allow_next),
    .out_valid  (m_ar_valid),
    .out_ready  (m_ar_ready),
    .out_data   (m_ar_payload)
  );

  // Last rides alongside the payload so the pair can never separate.
  assign r_in_data = {m_r_last, m_r_payload};

  axi_read_slice_skid #(
    .Width (RPayloadWidth + 1)
  ) u_r_skid (
    .clk        (clk),
    .areset_n   (areset_n),
    .in_valid   (m_r_valid),
    .in_ready   (m_r_ready),
    .in_data    (r_in_data),
    .allow_next (1'b1),
    .out_valid  (s_r_valid),
    .out_ready  (s_r_ready),
    .out_data   (r_out_data)
  );

  assign s_r_last    = r_out_data[RPayloadWidth];
  assign s_r_payload = r_out_data[RPayloadWidth-1:0];
  assign outstanding = count_reg;

endmodule

// File: tb/tb_axi_read_slice.sv
// Scoreboard bench for axi_read_slice: manager and subordinate models drive
// random and directed traffic; a monitor compares both channels and the
// outstanding count against a transaction-level model.

module tb_axi_read_slice;

  localparam int AW   = 41;
  localparam int RW   = 74;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          areset_n;
  logic          s_ar_valid, s_ar_ready;
  logic [AW-1:0] s_ar_payload;
  logic          m_ar_valid, m_ar_ready;
  logic [AW-1:0] m_ar_payload;
  logic          m_r_valid, m_r_ready;
  logic [RW-1:0] m_r_payload;
  logic          m_r_last;
  logic          s_r_valid, s_r_ready;
  logic [RW-1:0] s_r_payload;
  logic          s_r_last;
  logic [CW-1:0] outstanding;

  axi_read_slice #(
    .ArPayloadWidth (AW),
    .RPayloadWidth  (RW),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk          (clk),
    .areset_n     (areset_n),
    .s_ar_valid   (s_ar_valid),
    .s_ar_ready   (s_ar_ready),
    .s_ar_payload (s_ar_payload),
    .m_ar_valid   (m_ar_valid),
    .m_ar_ready   (m_ar_ready),
    .m_ar_payload (m_ar_payload),
    .m_r_valid    (m_r_valid),
    .m_r_ready    (m_r_ready),
    .m_r_payload  (m_r_payload),
    .m_r_last     (m_r_last),
    .s_r_valid    (s_r_valid),
    .s_r_ready    (s_r_ready),
    .s_r_payload  (s_r_payload),
    .s_r_last     (s_r_last),
    .outstanding  (outstanding)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // stimulus and scoreboard state
  logic [AW-1:0] ar_stim[$];
  logic [AW-1:0] ar_exp[$];
  int            ar_exp_cyc[$];
  logic [AW-1:0] sub_bursts[$];
  logic [RW:0]   r_exp[$];
  int            model_cnt = 0;
  int            n_acc = 0;
  int            n_simul = 0;
  int            n_sr_beats = 0;
  int            r_beat = 0;

  // knobs
  int ar_pct = 100, mar_pct = 100, r_pct = 100, sr_pct = 100;
  bit sr_toggle = 0, respond_en = 1;
  int r_budget = -1;
  bit stream_chk = 0;
  int n_stream = 0, first_m = 0, last_m = 0;

  // fire flags: evaluated at negedge for the upcoming rising edge
  bit ar_fire = 0, mar_fire = 0, mr_fire = 0, sr_fire = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [AW-1:0] mk_ar(input logic [7:0] id, input logic [19:0] addr,
                                          input logic [7:0] len);
    return {id, addr, len, 3'd3, 2'd1};
  endfunction

  // Manager: present queued ARs, hold each until accepted
  initial begin
    s_ar_valid   = 1'b0;
    s_ar_payload = '0;
    forever begin
      @(posedge clk); #1;
      if (!areset_n) continue;
      if (s_ar_valid && !ar_fire) continue;
      s_ar_valid = 1'b0;
      if (ar_stim.size() > 0 && $urandom_range(99) < ar_pct) begin
        s_ar_payload = ar_stim.pop_front();
        s_ar_valid   = 1'b1;
      end
    end
  end

  // Subordinate: answer each burst in order, arlen+1 beats, last on the final one
  initial begin
    logic [AW-1:0] b;
    logic [63:0]   rd;
    m_r_valid   = 1'b0;
    m_r_payload = '0;
    m_r_last    = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!areset_n) continue;
      if (m_r_valid && !mr_fire) continue;
      if (mr_fire) begin
        if (m_r_last) begin
          void'(sub_bursts.pop_front());
          r_beat = 0;
        end else begin
          r_beat++;
        end
      end
      m_r_valid = 1'b0;
      m_r_last  = 1'b0;
      if (respond_en && sub_bursts.size() > 0 && r_budget != 0 && $urandom_range(99) < r_pct) begin
        b  = sub_bursts[0];
        rd = {32'($urandom()), 32'(32'h1111 * (r_beat + 1))};
        m_r_payload = {b[40:33], rd, 2'($urandom_range(3))};
        m_r_last    = (r_beat == int'(b[12:5]));
        m_r_valid   = 1'b1;
        if (m_r_last && r_budget > 0) r_budget--;
      end
    end
  end

  // Ready drivers for the two downstream-facing handshakes
  initial begin
    m_ar_ready = 1'b0;
    s_r_ready  = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_ar_ready = ($urandom_range(99) < mar_pct);
      s_r_ready  = sr_toggle ? !s_r_ready : ($urandom_range(99) < sr_pct);
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [AW-1:0] ea;
    logic [RW:0]   er;
    int            ec;
    forever begin
      @(negedge clk);
      cyc++;
      if (!areset_n) begin
        ar_fire = 0; mar_fire = 0; mr_fire = 0; sr_fire = 0;
        continue;
      end
      chk("outstanding", 128'(outstanding), 128'(model_cnt));
      if (s_ar_ready) chk("ar_ready_cap", 128'(model_cnt < MAXO), 128'(1));
      ar_fire  = s_ar_valid && s_ar_ready;
      mar_fire = m_ar_valid && m_ar_ready;
      mr_fire  = m_r_valid && m_r_ready;
      sr_fire  = s_r_valid && s_r_ready;
      if (ar_fire) begin
        ar_exp.push_back(s_ar_payload);
        ar_exp_cyc.push_back(cyc);
        n_acc++;
        model_cnt++;
      end
      if (mar_fire) begin
        sub_bursts.push_back(m_ar_payload);
        if (ar_exp.size() == 0) begin
          chk("ar_unexpected", 128'(m_ar_payload), 128'(0));
        end else begin
          ea = ar_exp.pop_front();
          ec = ar_exp_cyc.pop_front();
          chk("ar_payload", 128'(m_ar_payload), 128'(ea));
          if (stream_chk) begin
            chk("ar_latency", 128'(cyc - ec), 128'(1));
            if (n_stream == 0) first_m = cyc;
            last_m = cyc;
            n_stream++;
          end
        end
      end
      if (mr_fire) r_exp.push_back({m_r_last, m_r_payload});
      if (sr_fire) begin
        n_sr_beats++;
        if (r_exp.size() == 0) begin
          chk("r_unexpected", 128'({s_r_last, s_r_payload}), 128'(0));
        end else begin
          er = r_exp.pop_front();
          chk("r_beat", 128'({s_r_last, s_r_payload}), 128'(er));
          if (er[RW]) begin
            if (ar_fire) n_simul++;
            model_cnt--;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!(ar_stim.size() == 0 && !s_ar_valid && ar_exp.size() == 0 && r_exp.size() == 0 &&
             sub_bursts.size() == 0 && model_cnt == 0 && !m_r_valid && !s_r_valid &&
             !m_ar_valid)) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        errors++;
        $display("FAIL idle_timeout actual=busy required=idle (cycle %0d)", cyc);
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int mark;
    int guard;
    // reset with a pending request on the AR input
    areset_n     = 1'b0;
    s_ar_valid   = 1'b1;
    s_ar_payload = mk_ar(8'h5a, 20'h12345, 8'd0);
    repeat (3) @(negedge clk);
    chk("rst_s_ar_ready", 128'(s_ar_ready), 128'(0));
    chk("rst_m_ar_valid", 128'(m_ar_valid), 128'(0));
    chk("rst_s_r_valid", 128'(s_r_valid), 128'(0));
    chk("rst_m_r_ready", 128'(m_r_ready), 128'(0));
    chk("rst_outstanding", 128'(outstanding), 128'(0));
    chk("rst_m_ar_payload", 128'(m_ar_payload), 128'(0));
    s_ar_valid = 1'b0;
    areset_n   = 1'b1;
    #1 chk("rel_ready_before_edge", 128'(s_ar_ready), 128'(0));
    @(posedge clk); #1;
    chk("rel_s_ar_ready", 128'(s_ar_ready), 128'(1));
    chk("rel_outstanding", 128'(outstanding), 128'(0));
    @(negedge clk);

    // streaming: 8 back-to-back single-beat reads
    stream_chk = 1;
    for (int i = 0; i < 8; i++) ar_stim.push_back(mk_ar(8'(i), 20'(i * 8), 8'd0));
    wait_idle();
    stream_chk = 0;
    chk("stream_count", 128'(n_stream), 128'(8));
    chk("stream_no_gaps", 128'(last_m - first_m), 128'(7));
    chk("stream_simul_seen", 128'(n_simul > 0), 128'(1));

    // AR backpressure: exactly two beats absorbed
    mar_pct = 0;
    mark = n_acc;
    for (int i = 0; i < 6; i++) ar_stim.push_back(mk_ar(8'(16 + i), 20'(i * 16), 8'd1));
    repeat (6) @(negedge clk);
    chk("bp_absorbed", 128'(n_acc - mark), 128'(2));
    chk("bp_s_ar_ready", 128'(s_ar_ready), 128'(0));
    mar_pct = 100;
    wait_idle();

    // outstanding cap
    respond_en = 0;
    mark = n_acc;
    for (int i = 0; i < 6; i++) ar_stim.push_back(mk_ar(8'(32 + i), 20'(i * 4), 8'd0));
    repeat (12) @(negedge clk);
    chk("cap_accepted", 128'(n_acc - mark), 128'(4));
    chk("cap_outstanding", 128'(outstanding), 128'(MAXO));
    chk("cap_s_ar_ready", 128'(s_ar_ready), 128'(0));
    r_budget   = 1;
    respond_en = 1;
    repeat (10) @(negedge clk);
    chk("cap_reopen_accepted", 128'(n_acc - mark), 128'(5));
    chk("cap_reopen_outstanding", 128'(outstanding), 128'(MAXO));
    r_budget = -1;
    wait_idle();

    // four-beat burst with toggling manager ready
    sr_toggle = 1;
    ar_stim.push_back(mk_ar(8'h77, 20'h00400, 8'd3));
    wait_idle();
    sr_toggle = 0;

    // reset in the middle of a long burst
    r_pct = 40;
    mark  = n_sr_beats;
    ar_stim.push_back(mk_ar(8'h99, 20'h00800, 8'd7));
    guard = 0;
    while (n_sr_beats - mark < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("midburst_progress", 128'(n_sr_beats - mark >= 2), 128'(1));
    #2 areset_n = 1'b0;
    #1;
    chk("midrst_s_r_valid", 128'(s_r_valid), 128'(0));
    chk("midrst_outstanding", 128'(outstanding), 128'(0));
    chk("midrst_m_ar_valid", 128'(m_ar_valid), 128'(0));
    ar_stim.delete(); ar_exp.delete(); ar_exp_cyc.delete();
    sub_bursts.delete(); r_exp.delete();
    model_cnt = 0; r_beat = 0;
    s_ar_valid = 1'b0; m_r_valid = 1'b0; m_r_last = 1'b0;
    ar_fire = 0; mar_fire = 0; mr_fire = 0; sr_fire = 0;
    repeat (2) @(negedge clk);
    #2 areset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_s_r_idle", 128'(s_r_valid), 128'(0));
      chk("post_rst_m_ar_idle", 128'(m_ar_valid), 128'(0));
    end

    // randomized traffic with varying rates
    for (int seg = 0; seg < 6; seg++) begin
      ar_pct  = $urandom_range(100, 30);
      mar_pct = $urandom_range(100, 30);
      r_pct   = $urandom_range(100, 30);
      sr_pct  = $urandom_range(100, 30);
      for (int i = 0; i < 40; i++)
        ar_stim.push_back(mk_ar(8'($urandom()), 20'($urandom()), 8'($urandom_range(3))));
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
